// File: rtl/uart_alu_sequencer_if.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer_if
// Bundles the byte stream from the UART receiver, the ALU operand/result
// path and the sequencer status outputs into one interface.
//   slave  : the sequencer (reads rx_* and alu_result/alu_flags, drives the rest)
//   master : the environment (UART receiver + ALU, or a testbench)
// Signals:
//   rx_data/rx_ready            received byte and its data-ready level
//   alu_a/alu_b/alu_op          registered operands and opcode to the ALU
//   alu_result/alu_flags        ALU result and N,Z,C,V flags
//   result/flags/result_valid   latched result, flags and one-cycle strobe
//   busy                        sequencer is not idle
//   err_opcode/timeout/overrun  one-cycle error strobes
//   cmd_count                   completed command counter (wraps)
// ---------------------------------------------------------------------------
interface uart_alu_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 4
);
   logic [DATA_W-1:0] rx_data;
   logic              rx_ready;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [OP_W-1:0]   alu_op;
   logic [DATA_W-1:0] alu_result;
   logic [3:0]        alu_flags;
   logic [DATA_W-1:0] result;
   logic [3:0]        flags;
   logic              result_valid;
   logic              busy;
   logic              err_opcode;
   logic              err_timeout;
   logic              err_overrun;
   logic [7:0]        cmd_count;

   modport slave (
      input  rx_data, rx_ready, alu_result, alu_flags,
      output alu_a, alu_b, alu_op, result, flags, result_valid, busy,
             err_opcode, err_timeout, err_overrun, cmd_count
   );

   modport master (
      output rx_data, rx_ready, alu_result, alu_flags,
      input  alu_a, alu_b, alu_op, result, flags, result_valid, busy,
             err_opcode, err_timeout, err_overrun, cmd_count
   );
endinterface

// File: rtl/uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// uart_alu_sequencer
// Collects a three-byte command (opcode, operand A, operand B) from the UART
// receiver, presents it to the ALU, waits ALU_LAT cycles, then latches the
// result/flags and strobes result_valid for one cycle. Bad opcodes, stalls
// between bytes of a command and bytes arriving while busy are reported on
// one-cycle error strobes.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - uart_alu_sequencer_if.slave (rx byte stream, ALU path, status)
// ---------------------------------------------------------------------------
module uart_alu_sequencer #(
   parameter int DATA_W       = 8,
   parameter int OP_W         = 4,
   parameter int NUM_OPS      = 10,
   parameter int ALU_LAT      = 1,
   parameter int TIMEOUT_CLKS = 8680
) (
   input  logic                 clk,
   input  logic                 rst,
   uart_alu_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, DONE} state_t;

   localparam int                LAT_W     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(ALU_LAT - 1);
   localparam logic [15:0]       TO_LAST   = 16'(TIMEOUT_CLKS - 1);
   // One bit wider than a byte so NUM_OPS up to 2**DATA_W compares correctly.
   localparam logic [DATA_W:0]   NUM_OPS_X = (DATA_W + 1)'(NUM_OPS);

   state_t              state_reg, state_next;
   logic                rdy_q_reg, rdy_q_next;
   logic [DATA_W-1:0]   alu_a_reg, alu_a_next;
   logic [DATA_W-1:0]   alu_b_reg, alu_b_next;
   logic [OP_W-1:0]     alu_op_reg, alu_op_next;
   logic [DATA_W-1:0]   result_reg, result_next;
   logic [3:0]          flags_reg, flags_next;
   logic                result_valid_reg, result_valid_next;
   logic                err_opcode_reg, err_opcode_next;
   logic                err_timeout_reg, err_timeout_next;
   logic                err_overrun_reg, err_overrun_next;
   logic [7:0]          cmd_count_reg, cmd_count_next;
   logic [15:0]         to_cnt_reg, to_cnt_next;
   logic [LAT_W-1:0]    lat_cnt_reg, lat_cnt_next;
   logic                rx_byte;

   // A byte is the rising edge of the ready level; a held level counts once.
   assign rx_byte = bus.rx_ready & ~rdy_q_reg;

   always_comb begin
      state_next        = state_reg;
      rdy_q_next        = bus.rx_ready;
      alu_a_next        = alu_a_reg;
      alu_b_next        = alu_b_reg;
      alu_op_next       = alu_op_reg;
      result_next       = result_reg;
      flags_next        = flags_reg;
      result_valid_next = 1'b0;
      err_opcode_next   = 1'b0;
      err_timeout_next  = 1'b0;
      err_overrun_next  = 1'b0;
      cmd_count_next    = cmd_count_reg;
      to_cnt_next       = to_cnt_reg;
      lat_cnt_next      = lat_cnt_reg;

      case (state_reg)
         IDLE: begin
            if (rx_byte) begin
               if ({1'b0, bus.rx_data} < NUM_OPS_X) begin
                  alu_op_next = bus.rx_data[OP_W-1:0];
                  to_cnt_next = '0;
                  state_next  = GET_A;
               end else begin
                  err_opcode_next = 1'b1;
               end
            end
         end

         GET_A: begin
            // An arriving byte beats an expiring timer in the same cycle.
            if (rx_byte) begin
               alu_a_next  = bus.rx_data;
               to_cnt_next = '0;
               state_next  = GET_B;
            end else if (to_cnt_reg == TO_LAST) begin
               err_timeout_next = 1'b1;
               state_next       = IDLE;
            end else begin
               to_cnt_next = to_cnt_reg + 16'd1;
            end
         end

         GET_B: begin
            if (rx_byte) begin
               alu_b_next   = bus.rx_data;
               to_cnt_next  = '0;
               lat_cnt_next = '0;
               state_next   = EXEC;
            end else if (to_cnt_reg == TO_LAST) begin
               err_timeout_next = 1'b1;
               state_next       = IDLE;
            end else begin
               to_cnt_next = to_cnt_reg + 16'd1;
            end
         end

         EXEC: begin
            if (rx_byte) begin
               err_overrun_next = 1'b1;
            end
            if (lat_cnt_reg == LAT_LAST) begin
               result_next       = bus.alu_result;
               flags_next        = bus.alu_flags;
               cmd_count_next    = cmd_count_reg + 8'd1;
               // Registered here so the strobe is high exactly in DONE.
               result_valid_next = 1'b1;
               state_next        = DONE;
            end else begin
               lat_cnt_next = lat_cnt_reg + LAT_W'(1);
            end
         end

         DONE: begin
            if (rx_byte) begin
               err_overrun_next = 1'b1;
            end
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         // Starts high so a ready line already asserted at reset is not a byte.
         rdy_q_reg        <= 1'b1;
         alu_a_reg        <= '0;
         alu_b_reg        <= '0;
         alu_op_reg       <= '0;
         result_reg       <= '0;
         flags_reg        <= '0;
         result_valid_reg <= 1'b0;
         err_opcode_reg   <= 1'b0;
         err_timeout_reg  <= 1'b0;
         err_overrun_reg  <= 1'b0;
         cmd_count_reg    <= '0;
         to_cnt_reg       <= '0;
         lat_cnt_reg      <= '0;
      end else begin
         state_reg        <= state_next;
         rdy_q_reg        <= rdy_q_next;
         alu_a_reg        <= alu_a_next;
         alu_b_reg        <= alu_b_next;
         alu_op_reg       <= alu_op_next;
         result_reg       <= result_next;
         flags_reg        <= flags_next;
         result_valid_reg <= result_valid_next;
         err_opcode_reg   <= err_opcode_next;
         err_timeout_reg  <= err_timeout_next;
         err_overrun_reg  <= err_overrun_next;
         cmd_count_reg    <= cmd_count_next;
         to_cnt_reg       <= to_cnt_next;
         lat_cnt_reg      <= lat_cnt_next;
      end
   end

   assign bus.alu_a        = alu_a_reg;
   assign bus.alu_b        = alu_b_reg;
   assign bus.alu_op       = alu_op_reg;
   assign bus.result       = result_reg;
   assign bus.flags        = flags_reg;
   assign bus.result_valid = result_valid_reg;
   assign bus.busy         = (state_reg != IDLE);
   assign bus.err_opcode   = err_opcode_reg;
   assign bus.err_timeout  = err_timeout_reg;
   assign bus.err_overrun  = err_overrun_reg;
   assign bus.cmd_count    = cmd_count_reg;
endmodule

// File: tb/tb_uart_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_sequencer
// Two sequencer instances share clk/rst: dut0 with ALU_LAT=1, dut1 with
// ALU_LAT=4. A stub ALU (add/sub/and/or/xor, else pass A) feeds each one.
// Strobes are counted by a monitor sampling on the falling edge; expected
// values come from a command-level model and a table of hand-computed vectors.
// ---------------------------------------------------------------------------
module tb_uart_alu_sequencer;
   localparam int DATA_W       = 8;
   localparam int OP_W         = 4;
   localparam int NUM_OPS      = 10;
   localparam int TIMEOUT_CLKS = 8680;
   localparam int LAT0         = 1;
   localparam int LAT1         = 4;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [3:0] flg;
   } vec_t;

   typedef struct packed {
      logic [7:0] result;
      logic [3:0] flags;
      logic [7:0] cnt;
      logic       busy;
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
   } snap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   int   rv_cnt[2];
   int   eo_cnt[2];
   int   et_cnt[2];
   int   ov_cnt[2];
   int   last_rv[2];
   int   last_et[2];

   vec_t vecs[6];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_alu_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus0 ();
   uart_alu_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus1 ();

   uart_alu_sequencer #(
      .DATA_W(DATA_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS),
      .ALU_LAT(LAT0), .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   uart_alu_sequencer #(
      .DATA_W(DATA_W), .OP_W(OP_W), .NUM_OPS(NUM_OPS),
      .ALU_LAT(LAT1), .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

   // Stub ALU: returns {N,Z,C,V,result}. Sub reports borrow in C.
   function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      logic [8:0] s;
      logic [7:0] r;
      logic       c;
      logic       v;
      s = '0;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd2: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[7:0];
            c = s[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'd3: begin
            r = a - b;
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'd4:    r = a & b;
         4'd5:    r = a | b;
         4'd6:    r = a ^ b;
         default: r = a;
      endcase
      return {r[7], (r == 8'd0), c, v, r};
   endfunction

   assign {bus0.alu_flags, bus0.alu_result} = alu_model(bus0.alu_op, bus0.alu_a, bus0.alu_b);
   assign {bus1.alu_flags, bus1.alu_result} = alu_model(bus1.alu_op, bus1.alu_a, bus1.alu_b);

   always @(negedge clk) begin
      if (bus0.result_valid) begin rv_cnt[0] <= rv_cnt[0] + 1; last_rv[0] <= cyc; end
      if (bus1.result_valid) begin rv_cnt[1] <= rv_cnt[1] + 1; last_rv[1] <= cyc; end
      if (bus0.err_timeout)  begin et_cnt[0] <= et_cnt[0] + 1; last_et[0] <= cyc; end
      if (bus1.err_timeout)  begin et_cnt[1] <= et_cnt[1] + 1; last_et[1] <= cyc; end
      if (bus0.err_opcode)   eo_cnt[0] <= eo_cnt[0] + 1;
      if (bus1.err_opcode)   eo_cnt[1] <= eo_cnt[1] + 1;
      if (bus0.err_overrun)  ov_cnt[0] <= ov_cnt[0] + 1;
      if (bus1.err_overrun)  ov_cnt[1] <= ov_cnt[1] + 1;
   end

   function automatic snap_t snap(input int s);
      snap_t r;
      if (s == 0) r = '{bus0.result, bus0.flags, bus0.cmd_count, bus0.busy,
                        bus0.alu_op, bus0.alu_a, bus0.alu_b};
      else        r = '{bus1.result, bus1.flags, bus1.cmd_count, bus1.busy,
                        bus1.alu_op, bus1.alu_a, bus1.alu_b};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic drive(input int s, input logic [7:0] d, input logic r);
      if (s == 0) begin bus0.rx_data = d; bus0.rx_ready = r; end
      else        begin bus1.rx_data = d; bus1.rx_ready = r; end
   endtask

   // Raises ready for 'hold' cycles then drops it for one; t_acc is the edge
   // number (value of cyc after that edge) at which the byte is sampled.
   task automatic send_byte(input int s, input logic [7:0] d, input int hold, output int t_acc);
      drive(s, d, 1'b1);
      t_acc = cyc + 1;
      tick(hold);
      drive(s, d, 1'b0);
      tick(1);
   endtask

   task automatic run_cmd(input int s, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input int hold, input int gap, output int t_b);
      int t;
      send_byte(s, op, hold, t);
      tick(gap);
      send_byte(s, a, hold, t);
      tick(gap);
      send_byte(s, b, hold, t_b);
   endtask

   task automatic check_cmd(input string name, input int s, input logic [7:0] op,
                            input logic [7:0] a, input logic [7:0] b, input logic [7:0] res,
                            input logic [3:0] flg, input int t_b, input int rv_before,
                            input int exp_cnt);
      snap_t sn;
      int    lat;
      lat = (s == 0) ? LAT0 : LAT1;
      tick(lat + 3);
      sn = snap(s);
      check({name, " result"}, sn.result, res);
      check({name, " flags"}, sn.flags, flg);
      check({name, " valid pulses"}, rv_cnt[s] - rv_before, 1);
      check({name, " valid edge"}, last_rv[s], t_b + lat);
      check({name, " cmd_count"}, sn.cnt, exp_cnt & 255);
      check({name, " busy"}, sn.busy, 0);
      check({name, " alu_op"}, sn.op, op & 15);
      check({name, " alu_a"}, sn.a, a);
      check({name, " alu_b"}, sn.b, b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int          t;
      int          t_a;
      int          t_b;
      int          rv;
      int          eo;
      int          et;
      int          ov;
      int          exp_cnt0;
      int          hold;
      int          gap;
      snap_t       sn;
      logic [11:0] e;
      logic [7:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  last_res;
      logic [3:0]  last_flg;

      vecs[0] = '{8'h03, 8'h10, 8'h20, 8'hF0, 4'hA};
      vecs[1] = '{8'h02, 8'h7F, 8'h01, 8'h80, 4'h9};
      vecs[2] = '{8'h04, 8'hF0, 8'h3C, 8'h30, 4'h0};
      vecs[3] = '{8'h06, 8'hAA, 8'hAA, 8'h00, 4'h4};
      vecs[4] = '{8'h05, 8'h0C, 8'h30, 8'h3C, 4'h0};
      vecs[5] = '{8'h09, 8'h81, 8'h22, 8'h81, 4'h8};

      // Ready line already high through reset must not count as a byte.
      drive(0, 8'h00, 1'b1);
      drive(1, 8'h00, 1'b0);
      tick(3);
      sn = snap(0);
      check("reset result", sn.result, 0);
      check("reset flags", sn.flags, 0);
      check("reset cmd_count", sn.cnt, 0);
      check("reset busy", sn.busy, 0);
      check("reset alu", {sn.op, sn.a, sn.b}, 0);
      check("reset strobes", {bus0.result_valid, bus0.err_opcode, bus0.err_timeout,
                              bus0.err_overrun}, 0);
      rst = 1'b0;
      tick(3);
      sn = snap(0);
      check("held line after reset busy", sn.busy, 0);
      check("held line after reset err_opcode", eo_cnt[0], 0);
      drive(0, 8'h00, 1'b0);
      tick(1);
      exp_cnt0 = 0;

      // Basic add.
      rv = rv_cnt[0];
      run_cmd(0, 8'h02, 8'h55, 8'hA3, 1, 0, t_b);
      exp_cnt0++;
      check_cmd("add55A3", 0, 8'h02, 8'h55, 8'hA3, 8'hF8, 4'h8, t_b, rv, exp_cnt0);

      // Bad opcode, then a carry-out add.
      eo = eo_cnt[0];
      send_byte(0, 8'h1F, 1, t);
      sn = snap(0);
      check("bad opcode pulses", eo_cnt[0] - eo, 1);
      check("bad opcode busy", sn.busy, 0);
      rv = rv_cnt[0];
      run_cmd(0, 8'h02, 8'hFF, 8'h01, 1, 0, t_b);
      exp_cnt0++;
      check_cmd("addFF01", 0, 8'h02, 8'hFF, 8'h01, 8'h00, 4'h6, t_b, rv, exp_cnt0);

      // Timeout after operand A.
      et = et_cnt[0];
      send_byte(0, 8'h02, 1, t);
      send_byte(0, 8'h10, 1, t_a);
      tick(TIMEOUT_CLKS + 10);
      sn = snap(0);
      check("timeout pulses", et_cnt[0] - et, 1);
      check("timeout edge", last_et[0], t_a + TIMEOUT_CLKS);
      check("timeout busy", sn.busy, 0);
      check("timeout alu_a kept", sn.a, 8'h10);
      check("timeout cmd_count", sn.cnt, exp_cnt0);
      rv = rv_cnt[0];
      run_cmd(0, 8'h02, 8'h01, 8'h01, 1, 0, t_b);
      exp_cnt0++;
      check_cmd("after timeout", 0, 8'h02, 8'h01, 8'h01, 8'h02, 4'h0, t_b, rv, exp_cnt0);

      // Byte arriving on the expiry cycle is accepted.
      et = et_cnt[0];
      rv = rv_cnt[0];
      send_byte(0, 8'h02, 1, t);
      send_byte(0, 8'h20, 1, t_a);
      tick(t_a + TIMEOUT_CLKS - 1 - cyc);
      send_byte(0, 8'h30, 1, t_b);
      exp_cnt0++;
      check_cmd("expiry byte wins", 0, 8'h02, 8'h20, 8'h30, 8'h50, 4'h0, t_b, rv, exp_cnt0);
      check("expiry byte no timeout", et_cnt[0] - et, 0);

      // Long-held ready level: one byte per rising edge.
      eo = eo_cnt[0];
      ov = ov_cnt[0];
      rv = rv_cnt[0];
      run_cmd(0, 8'h02, 8'h03, 8'h04, 500, 0, t_b);
      exp_cnt0++;
      check_cmd("held 500", 0, 8'h02, 8'h03, 8'h04, 8'h07, 4'h0, t_b, rv, exp_cnt0);
      check("held 500 no errors", (eo_cnt[0] - eo) + (ov_cnt[0] - ov), 0);

      // Table of hand-computed vectors.
      for (int i = 0; i < 6; i++) begin
         rv = rv_cnt[0];
         run_cmd(0, vecs[i].op, vecs[i].a, vecs[i].b, 1, i % 3, t_b);
         exp_cnt0++;
         check_cmd($sformatf("vec%0d", i), 0, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].flg, t_b, rv, exp_cnt0);
      end
      last_res = vecs[5].res;
      last_flg = vecs[5].flg;

      // Random commands against the command-level model.
      for (int i = 0; i < 40; i++) begin
         op   = 8'($urandom_range(0, 31));
         a    = 8'($urandom);
         b    = 8'($urandom);
         hold = $urandom_range(1, 3);
         gap  = $urandom_range(0, 4);
         if (op < NUM_OPS) begin
            rv = rv_cnt[0];
            run_cmd(0, op, a, b, hold, gap, t_b);
            exp_cnt0++;
            e = alu_model(op[3:0], a, b);
            last_res = e[7:0];
            last_flg = e[11:8];
            check_cmd($sformatf("rand%0d op%0d", i, op), 0, op, a, b, last_res, last_flg,
                      t_b, rv, exp_cnt0);
         end else begin
            eo = eo_cnt[0];
            send_byte(0, op, hold, t);
            tick(gap);
            sn = snap(0);
            check($sformatf("rand%0d bad op 0x%0h pulses", i, op), eo_cnt[0] - eo, 1);
            check($sformatf("rand%0d bad op busy", i), sn.busy, 0);
            check($sformatf("rand%0d result held", i), {sn.flags, sn.result},
                  {last_flg, last_res});
         end
      end

      // Reset in the middle of a command.
      send_byte(0, 8'h02, 1, t);
      send_byte(0, 8'h05, 1, t);
      sn = snap(0);
      check("pre-reset busy", sn.busy, 1);
      rv = rv_cnt[0];
      eo = eo_cnt[0];
      et = et_cnt[0];
      ov = ov_cnt[0];
      rst = 1'b1;
      tick(2);
      sn = snap(0);
      check("mid reset outputs", {sn.result, sn.flags, sn.cnt, sn.busy, sn.op, sn.a, sn.b}, 0);
      rst = 1'b0;
      tick(2);
      check("mid reset no strobes", (rv_cnt[0] - rv) + (eo_cnt[0] - eo) + (et_cnt[0] - et)
            + (ov_cnt[0] - ov), 0);
      exp_cnt0 = 0;
      rv = rv_cnt[0];
      run_cmd(0, 8'h02, 8'h05, 8'h06, 1, 0, t_b);
      exp_cnt0++;
      check_cmd("after reset", 0, 8'h02, 8'h05, 8'h06, 8'h0B, 4'h0, t_b, rv, exp_cnt0);

      // Overrun during EXEC on the ALU_LAT=4 instance.
      rv = rv_cnt[1];
      ov = ov_cnt[1];
      run_cmd(1, 8'h02, 8'h11, 8'h22, 1, 0, t_b);
      send_byte(1, 8'h77, 1, t);
      check_cmd("lat4 overrun", 1, 8'h02, 8'h11, 8'h22, 8'h33, 4'h0, t_b, rv, 1);
      check("lat4 overrun pulses", ov_cnt[1] - ov, 1);
      rv = rv_cnt[1];
      run_cmd(1, 8'h06, 8'h0F, 8'hFF, 1, 1, t_b);
      check_cmd("lat4 next cmd", 1, 8'h06, 8'h0F, 8'hFF, 8'hF0, 4'h8, t_b, rv, 2);
      check("lat4 no extra overrun", ov_cnt[1] - ov, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_alu_sequencer.md
# uart_alu_sequencer

Command sequencer between the UART receiver and the ALU. Collects a three-byte command (opcode, operand A, operand B) from the receiver's byte stream and drives the ALU operand/opcode inputs. Waits a fixed ALU latency, then latches the result and flags and presents them for one cycle with a valid strobe. Malformed opcodes, inter-byte stalls and bytes arriving while busy are reported on error strobes.

## Interface
- `DATA_W`, 8: byte and operand width.
- `OP_W`, 4: ALU opcode width (low `OP_W` bits of opcode byte).
- `NUM_OPS`, 10: opcodes 0..NUM_OPS-1 valid.
- `ALU_LAT`, 1: cycles from operand presentation to result sampling (≥1).
- `TIMEOUT_CLKS`, 8680: max clk cycles between bytes of one command (20 bit-times at 115200 baud / 50 MHz).

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input DATA_W: received byte from the UART receiver; stable while `rx_ready` is high.
- `rx_ready` input 1: UART data-ready level; each rising edge is one new byte.
- `alu_a`, `alu_b` output DATA_W: registered operands to the ALU.
- `alu_op` output OP_W: registered opcode to the ALU.
- `alu_result` input DATA_W: ALU result.
- `alu_flags` input 4: ALU flags (N,Z,C,V).
- `result` output DATA_W: latched result.
- `flags` output 4: latched flags.
- `result_valid` output 1: one-cycle strobe, `result`/`flags` updated.
- `busy` output 1: high in any state except IDLE.
- `err_opcode`, `err_timeout`, `err_overrun` output 1: one-cycle error strobes.
- `cmd_count` output 8: completed commands, wraps 255→0.

## Operation
- Byte accept: `rx_ready` registered into `rdy_q`; `rx_byte = rx_ready & ~rdy_q`. A level held high for many cycles is one byte.
- States IDLE → GET_A → GET_B → EXEC → DONE → IDLE.
- IDLE: on `rx_byte`, if `rx_data < NUM_OPS`, latch `alu_op <= rx_data[OP_W-1:0]` and go to GET_A. Otherwise pulse `err_opcode` and stay in IDLE.
- GET_A: on `rx_byte`, latch `alu_a` and go to GET_B.
- GET_B: on `rx_byte`, latch `alu_b`, clear the latency counter and go to EXEC.
- Timeout:
  - 16-bit counter runs only in GET_A/GET_B.
  - Cleared on every accepted byte and on entry from IDLE.
  - When it reaches TIMEOUT_CLKS-1 with no `rx_byte` that cycle: pulse `err_timeout` and go to IDLE. The partial command is discarded and `alu_*` keep their last values.
  - `rx_byte` in the same cycle as expiry wins; the byte is accepted.
- EXEC: count ALU_LAT cycles. On the last one, latch `result <= alu_result` and `flags <= alu_flags`, increment `cmd_count`, and go to DONE.
- DONE: `result_valid` = 1 for exactly this cycle, then IDLE.
- `rx_byte` in EXEC or DONE: byte dropped, `err_overrun` pulsed, state unaffected.
- `result`/`flags` hold their value until the next command completes.

## Timing
- Reset (async assert, sync release): state IDLE; `rdy_q` = 1, so a line already high is not a byte; all outputs 0; counters 0.
- Byte latched at clk edge t, where `rx_ready` = 1 and `rdy_q` = 0 are sampled at t.
- `alu_a`/`alu_b`/`alu_op` valid from the edge that accepts each byte; all three are stable from the edge B is accepted (t_B).
- Result captured at edge t_B + ALU_LAT.
- `result_valid` is high for the cycle following edge t_B + ALU_LAT; `busy` falls at edge t_B + ALU_LAT + 1.
- Error strobes are registered, high for one cycle following the triggering edge.
- Reset mid-command: partial command discarded, no strobe; the first post-reset byte is an opcode.
- Minimum inter-command spacing: a new opcode is accepted in the IDLE cycle after DONE.

## Test plan
- With a stub ALU doing add on op 2, send 0x02, 0x55, 0xA3. Required: `alu_op`=2, `alu_a`=0x55, `alu_b`=0xA3; `result`=0xF8 with `result_valid` pulsed once, ALU_LAT cycles after the B-accept edge; `cmd_count`=1.
- Send 0x1F, then 0x02, 0xFF, 0x01. Required: `err_opcode` one pulse, `busy` stays 0; the following command yields `result`=0x00 with flags Z=1, C=1.
- Send 0x02, 0x10, then idle TIMEOUT_CLKS+10 cycles. Required: one `err_timeout` pulse exactly TIMEOUT_CLKS cycles after the A-accept edge, state IDLE. Then 0x02, 0x01, 0x01 yields 0x02.
- Hold `rx_ready` high for 500 cycles per byte of the sequence 0x02, 0x03, 0x04. Required: exactly 3 bytes accepted, `result`=0x07.
- With ALU_LAT=4, pulse `rx_ready` during EXEC. Required: `err_overrun` one pulse, `result` unaffected; the next opcode is accepted normally.
- Assert `rst` in GET_B, then send 0x02, 0x05, 0x06. Required: all outputs 0 during reset, no strobes; `result`=0x0B, `cmd_count`=1.
